// File: rtl/clkctrl_pkg.sv
// -----------------------------------------------------------------------------
// clkctrl_pkg
// Shared definitions for the CPU clock-select request controller:
//   - clk_state_t : FSM state encoding (also exported on clk_state)
//   - address-region constants used to classify host (slow) accesses
//   - default LINGER / TIMEOUT values
//   - is_host_acc() : host-access decode helper
// -----------------------------------------------------------------------------
package clkctrl_pkg;

  typedef enum logic [1:0] {
    HS_RUN = 2'd0,
    REQ_LS = 2'd1,
    LS_RUN = 2'd2,
    REQ_HS = 2'd3
  } clk_state_t;

  // Top address bits [15:14] of the two regions that can live on the host bus
  localparam logic [1:0] REGION_HOST = 2'b11;  // 0xC000-0xFFFF, always host
  localparam logic [1:0] REGION_ROM  = 2'b10;  // 0x8000-0xBFFF, host unless shadowed

  localparam int LINGER_DEFAULT  = 4;
  localparam int TIMEOUT_DEFAULT = 255;

  // A valid cycle is a host access when it targets the host region, or the
  // ROM region while the local shadow copy is disabled.
  function automatic logic is_host_acc(input logic [1:0] region,
                                       input logic       valid,
                                       input logic       rom_shadow_en);
    logic hit;
    hit = (region == REGION_HOST) ||
          ((region == REGION_ROM) && !rom_shadow_en);
    return valid && hit;
  endfunction

endpackage

// File: rtl/clksel_req_ctrl_sync2.sv
// -----------------------------------------------------------------------------
// sync2
// Two-flop synchroniser bringing a clock-switch acknowledge into the CPU
// clock domain. Both flops clear on reset.
// Ports:
//   clk   : destination clock
//   rst_b : asynchronous active-low reset
//   d     : asynchronous input
//   q     : synchronised output (two cycles of latency)
// -----------------------------------------------------------------------------
module sync2 (
  input  logic clk,
  input  logic rst_b,
  input  logic d,
  output logic q
);

  logic meta;

  // Synchroniser chain
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/clksel_req_ctrl.sv
// -----------------------------------------------------------------------------
// clksel_req_ctrl
// Requests the high-speed (HS) or low-speed (LS) CPU clock from an external
// glitch-free clock switch, stalling the CPU via RDY while a switch is in
// flight. Host-bus accesses need LS; after LINGER consecutive non-host valid
// cycles in LS the block asks for HS again. A request that is not
// acknowledged within TIMEOUT cycles is abandoned in favour of LS and flagged
// in the sticky to_err bit.
// Parameters:
//   LINGER  : non-host valid cycles spent in LS_RUN before requesting HS
//   TIMEOUT : request-state cycles before abort (1..255)
// Ports:
//   cpuclk_in      : CPU clock
//   rst_b          : asynchronous active-low reset
//   cpu_addr       : CPU address
//   cpu_vda/vpa    : valid data / valid program address
//   rom_shadow_en  : 0x8000-0xBFFF is local when 1
//   hsclk_selected : HS acknowledge (asynchronous)
//   lsclk_selected : LS acknowledge (asynchronous)
//   err_clr        : clears to_err
//   hsclk_sel      : clock request, 1 = HS
//   cpu_rdy        : CPU RDY, 0 stalls
//   clk_state      : current FSM state
//   to_err         : sticky acknowledge-timeout flag
// -----------------------------------------------------------------------------
module clksel_req_ctrl
  import clkctrl_pkg::*;
#(
  parameter int LINGER  = LINGER_DEFAULT,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic        cpuclk_in,
  input  logic        rst_b,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_vda,
  input  logic        cpu_vpa,
  input  logic        rom_shadow_en,
  input  logic        hsclk_selected,
  input  logic        lsclk_selected,
  input  logic        err_clr,
  output logic        hsclk_sel,
  output logic        cpu_rdy,
  output logic [1:0]  clk_state,
  output logic        to_err
);

  localparam logic [7:0] LINGER_V = 8'(LINGER);
  // The abort fires in the cycle whose increment would reach TIMEOUT, so the
  // request state is occupied for exactly TIMEOUT cycles.
  localparam logic [7:0] TO_LAST  = 8'(TIMEOUT - 1);

  clk_state_t state;
  clk_state_t state_next;
  logic [7:0] linger_cnt;
  logic [7:0] linger_next;
  logic [7:0] wait_cnt;
  logic [7:0] wait_next;
  logic       to_err_next;
  logic       timeout_evt;
  logic       hs_ack;
  logic       ls_ack;
  logic       valid;
  logic       host_acc;
  logic       in_req;
  logic       addr_unused;

  sync2 u_sync_hs (
    .clk   (cpuclk_in),
    .rst_b (rst_b),
    .d     (hsclk_selected),
    .q     (hs_ack)
  );

  sync2 u_sync_ls (
    .clk   (cpuclk_in),
    .rst_b (rst_b),
    .d     (lsclk_selected),
    .q     (ls_ack)
  );

  // Only the region bits take part in the decode
  assign addr_unused = ^cpu_addr[13:0];

  assign valid    = cpu_vda | cpu_vpa;
  assign host_acc = is_host_acc(cpu_addr[15:14], valid, rom_shadow_en);
  assign in_req   = (state == REQ_LS) || (state == REQ_HS);

  // Next-state, linger counter and RDY decode
  always_comb begin
    state_next  = state;
    linger_next = linger_cnt;
    cpu_rdy     = 1'b1;
    timeout_evt = 1'b0;
    case (state)
      HS_RUN: begin
        // Stall the host access right away; it completes once LS is running
        cpu_rdy     = !host_acc;
        linger_next = LINGER_V;
        if (host_acc) begin
          state_next = REQ_LS;
        end else begin
          state_next = HS_RUN;
        end
      end
      REQ_LS: begin
        cpu_rdy     = 1'b0;
        linger_next = LINGER_V;
        if (wait_cnt == TO_LAST) begin
          timeout_evt = 1'b1;
          state_next  = LS_RUN;
        end else if (ls_ack && !hs_ack) begin
          state_next = LS_RUN;
        end else begin
          state_next = REQ_LS;
        end
      end
      LS_RUN: begin
        cpu_rdy = 1'b1;
        if (!valid || host_acc) begin
          linger_next = LINGER_V;
          state_next  = LS_RUN;
        end else if (linger_cnt == 8'd0) begin
          // Hold this non-host cycle so it executes on the HS clock
          cpu_rdy     = 1'b0;
          linger_next = LINGER_V;
          state_next  = REQ_HS;
        end else begin
          linger_next = linger_cnt - 8'd1;
          state_next  = LS_RUN;
        end
      end
      REQ_HS: begin
        cpu_rdy     = 1'b0;
        linger_next = LINGER_V;
        // New accesses never abort the request; a host access is handled
        // from HS_RUN once the switch has completed.
        if (wait_cnt == TO_LAST) begin
          timeout_evt = 1'b1;
          state_next  = LS_RUN;
        end else if (hs_ack && !ls_ack) begin
          state_next = HS_RUN;
        end else begin
          state_next = REQ_HS;
        end
      end
      default: begin
        cpu_rdy     = 1'b1;
        linger_next = LINGER_V;
        state_next  = LS_RUN;
      end
    endcase
  end

  // Saturating wait counter, cleared on entry to a request state
  always_comb begin
    wait_next = wait_cnt;
    if ((state_next != state) &&
        ((state_next == REQ_LS) || (state_next == REQ_HS))) begin
      wait_next = 8'd0;
    end else if (in_req && (wait_cnt != 8'hFF)) begin
      wait_next = wait_cnt + 8'd1;
    end else begin
      wait_next = wait_cnt;
    end
  end

  // Sticky timeout flag; a timeout in the same cycle beats err_clr
  always_comb begin
    to_err_next = to_err;
    if (timeout_evt) begin
      to_err_next = 1'b1;
    end else if (err_clr) begin
      to_err_next = 1'b0;
    end else begin
      to_err_next = to_err;
    end
  end

  // State and counter registers
  always_ff @(posedge cpuclk_in or negedge rst_b) begin
    if (!rst_b) begin
      state      <= LS_RUN;
      linger_cnt <= 8'd0;
      wait_cnt   <= 8'd0;
      to_err     <= 1'b0;
    end else begin
      state      <= state_next;
      linger_cnt <= linger_next;
      wait_cnt   <= wait_next;
      to_err     <= to_err_next;
    end
  end

  assign hsclk_sel = (state == HS_RUN) || (state == REQ_HS);
  assign clk_state = state;

endmodule

// File: tb/tb_clksel_req_ctrl.sv
// -----------------------------------------------------------------------------
// tb_clksel_req_ctrl
// Directed self-checking bench for clksel_req_ctrl. Expected output vectors
// {clk_state, hsclk_sel, cpu_rdy, to_err} are queued when a step is driven
// and popped/compared once the DUT outputs have settled (negedge, or shortly
// after an asynchronous reset assertion).
// -----------------------------------------------------------------------------
module tb_clksel_req_ctrl;
  import clkctrl_pkg::*;

  logic        cpuclk_in;
  logic        rst_b;
  logic [15:0] cpu_addr;
  logic        cpu_vda;
  logic        cpu_vpa;
  logic        rom_shadow_en;
  logic        hsclk_selected;
  logic        lsclk_selected;
  logic        err_clr;
  logic        hsclk_sel;
  logic        cpu_rdy;
  logic [1:0]  clk_state;
  logic        to_err;

  typedef struct packed {
    logic [1:0] st;
    logic       hs;
    logic       rdy;
    logic       err;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];
  int    total = 0;
  int    bad   = 0;

  clksel_req_ctrl dut (
    .cpuclk_in      (cpuclk_in),
    .rst_b          (rst_b),
    .cpu_addr       (cpu_addr),
    .cpu_vda        (cpu_vda),
    .cpu_vpa        (cpu_vpa),
    .rom_shadow_en  (rom_shadow_en),
    .hsclk_selected (hsclk_selected),
    .lsclk_selected (lsclk_selected),
    .err_clr        (err_clr),
    .hsclk_sel      (hsclk_sel),
    .cpu_rdy        (cpu_rdy),
    .clk_state      (clk_state),
    .to_err         (to_err)
  );

  initial cpuclk_in = 1'b0;
  always #5 cpuclk_in = ~cpuclk_in;

  task automatic push(input string tag, input logic [1:0] st, input logic hs,
                      input logic rdy, input logic err);
    exp_t e;
    e.st  = st;
    e.hs  = hs;
    e.rdy = rdy;
    e.err = err;
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic drain();
    exp_t  e;
    exp_t  obs;
    string tag;
    while (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      tag = tag_q.pop_front();
      obs = {clk_state, hsclk_sel, cpu_rdy, to_err};
      total++;
      assert (obs === e) else begin
        bad++;
        $error("FAIL %s observed st=%0d hs=%b rdy=%b err=%b expected st=%0d hs=%b rdy=%b err=%b",
               tag, obs.st, obs.hs, obs.rdy, obs.err, e.st, e.hs, e.rdy, e.err);
      end
    end
  endtask

  // Queue an expectation for the current cycle and compare at the negedge
  task automatic step(input string tag, input logic [1:0] st, input logic hs,
                      input logic rdy, input logic err);
    push(tag, st, hs, rdy, err);
    @(negedge cpuclk_in);
    drain();
  endtask

  task automatic tick();
    @(posedge cpuclk_in);
    #1;
  endtask

  // From LS_RUN with the linger counter at LINGER: run non-host cycles until
  // HS is requested, hold acks for 3 cycles, then flip them and reach HS_RUN.
  task automatic go_hs();
    cpu_addr = 16'h1000;
    cpu_vda  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step("ls_linger", LS_RUN, 1'b0, 1'b1, 1'b0);
      tick();
    end
    step("ls_req_cycle", LS_RUN, 1'b0, 1'b0, 1'b0);
    tick();
    for (int i = 0; i < 3; i++) begin
      step("req_hs_noack", REQ_HS, 1'b1, 1'b0, 1'b0);
      tick();
    end
    hsclk_selected = 1'b1;
    lsclk_selected = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step("req_hs_sync", REQ_HS, 1'b1, 1'b0, 1'b0);
      tick();
    end
    step("hs_run", HS_RUN, 1'b1, 1'b1, 1'b0);
  endtask

  // From HS_RUN: a host access stalls at once, REQ_LS follows, LS_RUN is
  // reached once the LS acknowledge has crossed the synchroniser.
  task automatic go_ls(input logic [15:0] addr);
    cpu_addr = addr;
    cpu_vda  = 1'b1;
    step("hs_host_stall", HS_RUN, 1'b1, 1'b0, 1'b0);
    tick();
    hsclk_selected = 1'b0;
    lsclk_selected = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step("req_ls_sync", REQ_LS, 1'b0, 1'b0, 1'b0);
      tick();
    end
    step("ls_run_host", LS_RUN, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    rst_b          = 1'b0;
    cpu_addr       = 16'h0000;
    cpu_vda        = 1'b0;
    cpu_vpa        = 1'b0;
    rom_shadow_en  = 1'b0;
    hsclk_selected = 1'b0;
    lsclk_selected = 1'b1;
    err_clr        = 1'b0;

    // Reset state
    step("reset", LS_RUN, 1'b0, 1'b1, 1'b0);
    tick();
    tick();
    rst_b = 1'b1;
    step("post_reset_idle", LS_RUN, 1'b0, 1'b1, 1'b0);
    tick();

    // LS -> HS after the linger period
    go_hs();
    tick();

    // Host read in HS_RUN -> back to LS
    go_ls(16'hFE40);
    tick();

    // ROM region: local when shadowed, host otherwise
    go_hs();
    tick();
    rom_shadow_en = 1'b1;
    cpu_addr      = 16'h9000;
    step("shadow_local", HS_RUN, 1'b1, 1'b1, 1'b0);
    tick();
    step("shadow_stay", HS_RUN, 1'b1, 1'b1, 1'b0);
    tick();
    rom_shadow_en = 1'b0;
    go_ls(16'h9000);
    tick();

    // Request with no acknowledge -> timeout after 255 cycles in REQ_HS
    cpu_addr = 16'h1000;
    cpu_vda  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step("to_linger", LS_RUN, 1'b0, 1'b1, 1'b0);
      tick();
    end
    step("to_req_cycle", LS_RUN, 1'b0, 1'b0, 1'b0);
    tick();
    cpu_vda = 1'b0;
    for (int i = 0; i < 255; i++) begin
      step("to_wait", REQ_HS, 1'b1, 1'b0, 1'b0);
      tick();
    end
    step("timeout_abort", LS_RUN, 1'b0, 1'b1, 1'b1);
    tick();
    step("to_err_sticky", LS_RUN, 1'b0, 1'b1, 1'b1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    step("err_cleared", LS_RUN, 1'b0, 1'b1, 1'b0);
    tick();

    // Host access during REQ_HS: request completes, then REQ_LS
    cpu_addr = 16'h1000;
    cpu_vda  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step("r36_linger", LS_RUN, 1'b0, 1'b1, 1'b0);
      tick();
    end
    step("r36_req_cycle", LS_RUN, 1'b0, 1'b0, 1'b0);
    tick();
    cpu_addr = 16'hC000;
    for (int i = 0; i < 3; i++) begin
      step("r36_req_hs_host", REQ_HS, 1'b1, 1'b0, 1'b0);
      tick();
    end
    hsclk_selected = 1'b1;
    lsclk_selected = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step("r36_req_hs_sync", REQ_HS, 1'b1, 1'b0, 1'b0);
      tick();
    end
    step("r36_hs_run_host", HS_RUN, 1'b1, 1'b0, 1'b0);
    tick();
    step("r36_req_ls", REQ_LS, 1'b0, 1'b0, 1'b0);
    tick();
    step("r36_req_ls_hold", REQ_LS, 1'b0, 1'b0, 1'b0);
    tick();

    // Asynchronous reset mid-request
    rst_b = 1'b0;
    push("async_reset", LS_RUN, 1'b0, 1'b1, 1'b0);
    #1;
    drain();
    tick();
    cpu_vda        = 1'b0;
    hsclk_selected = 1'b0;
    lsclk_selected = 1'b1;
    rst_b          = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step("post_reset_quiet", LS_RUN, 1'b0, 1'b1, 1'b0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/clksel_req_ctrl.md
CLKSEL_REQ_CTRL -- requirements
Module: clksel_req_ctrl

Interface
REQ-001 Parameter LINGER, default 4, the number of consecutive non-host valid cycles spent in LS_RUN before the block requests HS.
REQ-002 Parameter TIMEOUT, default 255, the maximum number of cycles a request state may wait for acknowledge before the block aborts.
REQ-003 cpuclk_in  input  1  CPU clock; all state updates on posedge.
REQ-004 rst_b  input  1  reset, asynchronous, active-low.
REQ-005 cpu_addr  input  16  CPU address for the current cycle.
REQ-006 cpu_vda, cpu_vpa  input  1 each  65816 valid data / valid program address.
REQ-007 rom_shadow_en  input  1  when 1, 0x8000-0xBFFF is local (fast) memory.
REQ-008 hsclk_selected, lsclk_selected  input  1 each  acknowledges from the clock switch; asynchronous to cpuclk_in.
REQ-009 err_clr  input  1  clears the sticky timeout flag.
REQ-010 hsclk_sel  output  1  request to the clock switch: 1 = HS, 0 = LS.
REQ-011 cpu_rdy  output  1  CPU RDY; 0 stalls the CPU.
REQ-012 clk_state  output  2  current FSM state encoding.
REQ-013 to_err  output  1  sticky flag for an acknowledge timeout.

Function
REQ-014 Valid = cpu_vda | cpu_vpa; host_acc = valid & (addr[15:14]==2'b11 | (addr[15:14]==2'b10 & !rom_shadow_en)).
REQ-015 hsclk_selected and lsclk_selected SHALL each pass through a 2-flop synchroniser (hs_ack, ls_ack) before use.
REQ-016 States: HS_RUN=0, REQ_LS=1, LS_RUN=2, REQ_HS=3; hsclk_sel=1 in HS_RUN/REQ_HS, 0 in REQ_LS/LS_RUN.
REQ-017 HS_RUN: host_acc -> REQ_LS next edge; cpu_rdy=!host_acc combinationally in the same cycle.
REQ-018 REQ_LS: cpu_rdy=0; ls_ack=1 & hs_ack=0 -> LS_RUN.
REQ-019 LS_RUN: cpu_rdy=1; linger counter reloads to LINGER on host_acc or !valid and decrements on valid non-host cycles.
REQ-020 LS_RUN: a valid non-host cycle with counter==0 -> REQ_HS, and cpu_rdy=0 in that cycle.
REQ-021 REQ_HS: cpu_rdy=0; hs_ack=1 & ls_ack=0 -> HS_RUN.
REQ-022 A request state SHALL never abort on a new access: a host_acc during REQ_HS completes REQ_HS->HS_RUN, then goes to REQ_LS.
REQ-023 The wait counter (8 bits, saturating) clears on entry to REQ_LS/REQ_HS and increments each cycle spent in them.
REQ-024 Wait counter reaching TIMEOUT SHALL set to_err and force LS_RUN (hsclk_sel=0, cpu_rdy=1, linger reloaded).
REQ-025 err_clr clears to_err next edge; a simultaneous timeout event wins.
REQ-026 Both acks high, or both low, SHALL be treated as "not acknowledged".

Reset
REQ-027 rst_b low asynchronously forces LS_RUN, linger counter=0, wait counter=0, synchronisers=0, to_err=0.
REQ-028 Reset outputs: hsclk_sel=0, cpu_rdy=1, clk_state=2.
REQ-029 Reset asserted mid-request SHALL abandon the request with no residual state.

Structure
REQ-030 The state encodings, the address-region constants, and the LINGER/TIMEOUT defaults belong in the shared package clkctrl_pkg.
REQ-031 The one sub-module is sync2, the 2-flop synchroniser, instanced twice.

Verification
REQ-032 Release reset, addr=0x1000 valid, acks flip after 3 cycles -> after 4 non-host valid cycles: REQ_HS, hsclk_sel=1, cpu_rdy=0; HS_RUN 2 cycles after hs_ack is applied.
REQ-033 In HS_RUN, read 0xFE40 -> cpu_rdy=0 same cycle, REQ_LS next edge, LS_RUN 2 cycles after ls_ack, then cpu_rdy=1.
REQ-034 rom_shadow_en=1, access 0x9000 in HS_RUN -> stays HS_RUN, cpu_rdy=1; with rom_shadow_en=0 -> REQ_LS.
REQ-035 REQ_HS with acks never changing -> after 255 cycles to_err=1, state LS_RUN, hsclk_sel=0; err_clr pulse -> to_err=0.
REQ-036 host_acc during REQ_HS -> HS_RUN is reached, then REQ_LS; pulsing rst_b low mid-REQ_LS -> immediate LS_RUN with reset outputs.
